prefetch_queue: RTL and testbench
=================================

// Module: prefetch_queue
// PURPOSE
//  Instruction-byte prefetch buffer between the control unit fetch path and the memory port.
//  Reads opcode/immediate bytes ahead of the CU from a running fetch address into a DEPTH-entry FIFO.
//  The CU pops bytes in order; a flush (jp/call/ret/taken djnz) discards queued bytes and restarts at a new address.
//  Generalises the CU's single-byte fetch/wait_for_byte handshake to a parametrised depth and address width.
// PARAMETERS
//  DEPTH     4        FIFO entries (bytes); power of two, >= 2
//  ADDR_W    16       memory address width
//  RESET_PC  16'h1000 fetch/head address after reset (ADDR_W bits)
// PORTS
//  clk            in   1       system clock, rising edge
//  nrst           in   1       asynchronous active-low reset
//  flush          in   1       discard queue, restart fetch at flush_addr
//  flush_addr     in   ADDR_W  new fetch address, sampled when flush=1
//  cu_pop         in   1       CU consumes head byte this cycle
//  cu_byte_valid  out  1       queue non-empty; cu_byte/cu_pc valid
//  cu_byte        out  8       head byte
//  cu_pc          out  ADDR_W  address of head byte (= PC of next byte to execute)
//  mem_addr       out  ADDR_W  read address
//  mem_read_en    out  1       read request, held until mem_ack
//  dbl_byte_en    out  1       two-byte read (only with PREFETCH_DBL_EN)
//  mem_data_in    in   16      read data; [7:0] @mem_addr, [15:8] @mem_addr+1
//  mem_ack        in   1       read complete, data valid this cycle
// BEHAVIOUR
//  - Reset (async, nrst=0): state IDLE, count 0, fetch_addr=cu_pc=mem_addr=RESET_PC,
//    mem_read_en=0, dbl_byte_en=0, cu_byte_valid=0, cu_byte=8'h00.
//  - FSM states: IDLE, READ, DISCARD. mem_read_en=1 in READ and DISCARD only.
//  - IDLE -> READ when free slots >= 1 and flush=0; mem_addr=fetch_addr, frozen for the whole request.
//  - READ + mem_ack: push byte(s) at tail, fetch_addr += 1 (or 2); stay READ if free slots remain
//    after this cycle's push/pop, else IDLE. Back-to-back reads: no idle cycle.
//  - Latency: byte acked in cycle N appears as cu_byte_valid=1 in cycle N+1 (registered push).
//  - Pop: cu_pop & cu_byte_valid -> head advances, cu_pc += 1 (mod 2^ADDR_W). cu_pop on empty ignored.
//  - Push and pop in same cycle: count unchanged; full queue never requests, so no overflow.
//  - Flush (highest priority): next cycle count=0, cu_byte_valid=0, cu_pc=fetch_addr=flush_addr.
//      IDLE -> IDLE (request issued following cycle). READ without ack -> DISCARD.
//      READ with mem_ack same cycle -> data dropped, -> IDLE. DISCARD -> DISCARD (new addr taken).
//      cu_pop coincident with flush ignored.
//  - DISCARD: keep old mem_addr, mem_read_en=1 until mem_ack; data dropped; -> IDLE.
//    Memory requests are never aborted mid-handshake.
//  - Address arithmetic modulo 2^ADDR_W: 16'hFFFF + 1 = 16'h0000 for fetch_addr and cu_pc.
//  - Reset mid-request: all state cleared immediately; mem_read_en deasserts asynchronously.
// CONFIGURATION
//  PREFETCH_DBL_EN defined: in IDLE/READ, if free slots >= 2 and fetch_addr != all-ones, issue
//    dbl_byte_en=1; on ack push [7:0] then [15:8], fetch_addr += 2. Otherwise single-byte read.
//  PREFETCH_DBL_EN undefined: dbl_byte_en tied 0; always single-byte reads, [15:8] ignored.
// TESTING
//  1 Reset, mem_data_in=16'h003E, mem_ack on 1st request -> mem_addr=16'h1000, next cycle
//    cu_byte_valid=1, cu_byte=8'h3E, cu_pc=16'h1000.
//  2 Ack every request, no pops -> exactly DEPTH(4) reads at 1000..1003, then mem_read_en=0;
//    pop once -> cu_pc=16'h1001, one new read at 16'h1004.
//  3 Flush flush_addr=16'h1234 while READ pending at 16'h1002 -> DISCARD, mem_addr stays 1002;
//    ack with 8'hAA -> dropped; next read at 16'h1234, cu_byte_valid=0 until its ack.
//  4 Flush to 16'hFFFF, ack bytes 8'h11, 8'h22 -> reads at FFFF then 0000; pops give cu_pc FFFF, 0000.
//  5 PREFETCH_DBL_EN, reset, ack 16'h1234 -> dbl_byte_en=1 at 16'h1000; cu_byte 8'h34 then 8'h12
//    after pop; next read at 16'h1002.
//  6 nrst low during pending READ -> mem_read_en=0 immediately, cu_pc=16'h1000, queue empty.

Source files
------------

// File: rtl/prefetch_queue.sv
// Instruction-byte prefetch FIFO between the CU fetch path and the memory read port.
// Optional feature macro: PREFETCH_DBL_EN enables two-byte memory reads when room allows.
module prefetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h1000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  input  logic              cu_pop,
  output logic              cu_byte_valid,
  output logic [7:0]        cu_byte,
  output logic [ADDR_W-1:0] cu_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              dbl_byte_en,
  input  logic [15:0]       mem_data_in,
  input  logic              mem_ack,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Handshake: mem_read_en rises with a request and holds, with mem_addr and
  // dbl_byte_en frozen, until the cycle mem_ack=1; that cycle completes it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] cu_pc_q, cu_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              dbl_q, dbl_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]        mem_q [DEPTH];

  logic              pop_ok;
  logic [CNT_W-1:0]  pop_n;
  logic [CNT_W-1:0]  push_n;
  logic [CNT_W-1:0]  cnt_after;
  logic              we0, we1;
  logic [PTR_W-1:0]  widx1;
  logic              unused_hi;

`ifdef PREFETCH_DBL_EN
  assign unused_hi = 1'b0;
`else
  assign unused_hi = ^mem_data_in[15:8];
`endif

  assign pop_ok = cu_pop && (count_q != '0) && !flush;
  assign pop_n  = {{(CNT_W-1){1'b0}}, pop_ok};
  assign widx1  = wr_ptr_q + PTR_W'(1);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    cu_pc_d      = cu_pc_q;
    mem_addr_d   = mem_addr_q;
    dbl_d        = dbl_q;
    push_n       = '0;
    we0          = 1'b0;
    we1          = 1'b0;
    cnt_after    = count_q - pop_n;

    case (state_q)
      IDLE: begin
        if (!flush && (count_q < DEPTH_C)) begin
          state_d    = READ;
          mem_addr_d = fetch_addr_q;
`ifdef PREFETCH_DBL_EN
          dbl_d = (count_q <= DEPTH_C - CNT_W'(2)) && (fetch_addr_q != '1);
`else
          dbl_d = 1'b0;
`endif
        end
      end
      READ: begin
        if (flush) begin
          // An ack coinciding with flush completes the old request; its data is dropped.
          state_d = mem_ack ? IDLE : DISCARD;
          if (mem_ack) dbl_d = 1'b0;
        end else if (mem_ack) begin
          we0 = 1'b1;
          we1 = dbl_q;
          if (dbl_q) begin
            push_n       = CNT_W'(2);
            fetch_addr_d = fetch_addr_q + ADDR_W'(2);
          end else begin
            push_n       = CNT_W'(1);
            fetch_addr_d = fetch_addr_q + ADDR_W'(1);
          end
          cnt_after = count_q + push_n - pop_n;
          if (cnt_after < DEPTH_C) begin
            state_d    = READ;
            mem_addr_d = fetch_addr_d;
`ifdef PREFETCH_DBL_EN
            dbl_d = (cnt_after <= DEPTH_C - CNT_W'(2)) && (fetch_addr_d != '1);
`else
            dbl_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
            dbl_d   = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_d = IDLE;
          dbl_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        dbl_d   = 1'b0;
      end
    endcase

    count_d  = count_q + push_n - pop_n;
    rd_ptr_d = rd_ptr_q + (pop_ok ? PTR_W'(1) : PTR_W'(0));
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    if (pop_ok) cu_pc_d = cu_pc_q + ADDR_W'(1);

    if (flush) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fetch_addr_d = flush_addr;
      cu_pc_d      = flush_addr;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      cu_pc_q      <= RESET_PC;
      mem_addr_q   <= RESET_PC;
      dbl_q        <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      cu_pc_q      <= cu_pc_d;
      mem_addr_q   <= mem_addr_d;
      dbl_q        <= dbl_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      if (we0) mem_q[wr_ptr_q] <= mem_data_in[7:0];
      if (we1) mem_q[widx1]    <= mem_data_in[15:8];
    end
  end

  assign cu_byte_valid = (count_q != '0);
  assign cu_byte       = cu_byte_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign cu_pc         = cu_pc_q;
  assign mem_addr      = mem_addr_q;
  assign mem_read_en   = (state_q != IDLE);
`ifdef PREFETCH_DBL_EN
  assign dbl_byte_en   = dbl_q && mem_read_en;
`else
  assign dbl_byte_en   = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed self-checking bench for prefetch_queue; inputs change on the falling edge, outputs sampled there.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_addr = 16'h0000;
  logic        cu_pop = 1'b0;
  logic        cu_byte_valid;
  logic [7:0]  cu_byte;
  logic [15:0] cu_pc;
  logic [15:0] mem_addr;
  logic        mem_read_en;
  logic        dbl_byte_en;
  logic [15:0] mem_data_in = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_e;

  localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_DISCARD = 2'd2;

  prefetch_queue #(.DEPTH(4), .ADDR_W(16), .RESET_PC(16'h1000)) dut (
    .clk(clk), .nrst(nrst), .flush(flush), .flush_addr(flush_addr),
    .cu_pop(cu_pop), .cu_byte_valid(cu_byte_valid), .cu_byte(cu_byte),
    .cu_pc(cu_pc), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .dbl_byte_en(dbl_byte_en), .mem_data_in(mem_data_in), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic ack(input logic [15:0] data);
    mem_ack     = 1'b1;
    mem_data_in = data;
    step();
    mem_ack     = 1'b0;
  endtask

  task automatic pop1();
    cu_pop = 1'b1;
    step();
    cu_pop = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_rden", 32'(mem_read_en), 0);
    check("rst_dbl", 32'(dbl_byte_en), 0);
    check("rst_valid", 32'(cu_byte_valid), 0);
    check("rst_byte", 32'(cu_byte), 32'h00);
    check("rst_pc", 32'(cu_pc), 32'h1000);
    check("rst_maddr", 32'(mem_addr), 32'h1000);
    nrst = 1'b1;
    step();

`ifdef PREFETCH_DBL_EN
    check("t5_rden", 32'(mem_read_en), 1);
    check("t5_dbl", 32'(dbl_byte_en), 1);
    check("t5_maddr", 32'(mem_addr), 32'h1000);
    ack(16'h1234);
    check("t5_byte0", 32'(cu_byte), 32'h34);
    check("t5_pc0", 32'(cu_pc), 32'h1000);
    check("t5_next_maddr", 32'(mem_addr), 32'h1002);
    check("t5_next_dbl", 32'(dbl_byte_en), 1);
    pop1();
    check("t5_byte1", 32'(cu_byte), 32'h12);
    check("t5_pc1", 32'(cu_pc), 32'h1001);
    check("t5_valid1", 32'(cu_byte_valid), 1);
`else
    // Test 1: first request and one-cycle push latency
    check("t1_rden", 32'(mem_read_en), 1);
    check("t1_dbl", 32'(dbl_byte_en), 0);
    check("t1_maddr", 32'(mem_addr), 32'h1000);
    check("t1_valid_pre", 32'(cu_byte_valid), 0);
    ack(16'h003E);
    check("t1_valid", 32'(cu_byte_valid), 1);
    check("t1_byte", 32'(cu_byte), 32'h3E);
    check("t1_pc", 32'(cu_pc), 32'h1000);

    // Test 2: fill to DEPTH, stop requesting, then refill after a pop
    for (int i = 1; i < 4; i++) begin
      check($sformatf("t2_maddr%0d", i), 32'(mem_addr), 32'h1000 + i);
      check($sformatf("t2_rden%0d", i), 32'(mem_read_en), 1);
      ack(16'hFF00 | 16'(i));
    end
    check("t2_full_rden", 32'(mem_read_en), 0);
    step(2);
    check("t2_full_hold", 32'(mem_read_en), 0);
    check("t2_full_byte", 32'(cu_byte), 32'h3E);
    pop1();
    check("t2_pop_pc", 32'(cu_pc), 32'h1001);
    check("t2_pop_byte", 32'(cu_byte), 32'h01);
    step();
    check("t2_refill_rden", 32'(mem_read_en), 1);
    check("t2_refill_maddr", 32'(mem_addr), 32'h1004);
    ack(16'h0044);
    check("t2_full2_rden", 32'(mem_read_en), 0);
    exp_q.push_back({16'h1001, 8'h01});
    exp_q.push_back({16'h1002, 8'h02});
    exp_q.push_back({16'h1003, 8'h03});
    exp_q.push_back({16'h1004, 8'h44});
    while (exp_q.size() != 0) begin
      exp_e = exp_q.pop_front();
      check("t2_drain_valid", 32'(cu_byte_valid), 1);
      check("t2_drain_byte", 32'(cu_byte), 32'(exp_e[7:0]));
      check("t2_drain_pc", 32'(cu_pc), 32'(exp_e[23:8]));
      pop1();
    end
    check("t2_empty_valid", 32'(cu_byte_valid), 0);
    check("t2_empty_pc", 32'(cu_pc), 32'h1005);
    pop1();
    check("t2_emptypop_pc", 32'(cu_pc), 32'h1005);
    check("t2_emptypop_byte", 32'(cu_byte), 32'h00);
    check("t2_pending_maddr", 32'(mem_addr), 32'h1005);

    // Test 6: asynchronous reset during a pending read
    check("t6_pre_rden", 32'(mem_read_en), 1);
    nrst = 1'b0;
    #1;
    check("t6_rden", 32'(mem_read_en), 0);
    check("t6_pc", 32'(cu_pc), 32'h1000);
    check("t6_valid", 32'(cu_byte_valid), 0);
    check("t6_maddr", 32'(mem_addr), 32'h1000);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // Test 3: flush during a pending read at 1002
    ack(16'h0010);
    ack(16'h0011);
    check("t3_maddr", 32'(mem_addr), 32'h1002);
    flush = 1'b1;
    flush_addr = 16'h1234;
    cu_pop = 1'b1;
    step();
    flush = 1'b0;
    cu_pop = 1'b0;
    check("t3_state", 32'(dbg_state), 32'(S_DISCARD));
    check("t3_rden", 32'(mem_read_en), 1);
    check("t3_hold_maddr", 32'(mem_addr), 32'h1002);
    check("t3_valid", 32'(cu_byte_valid), 0);
    check("t3_pc", 32'(cu_pc), 32'h1234);
    step();
    check("t3_hold2_maddr", 32'(mem_addr), 32'h1002);
    ack(16'h00AA);
    check("t3_drop_valid", 32'(cu_byte_valid), 0);
    check("t3_drop_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    check("t3_new_maddr", 32'(mem_addr), 32'h1234);
    check("t3_new_valid", 32'(cu_byte_valid), 0);
    ack(16'h005A);
    check("t3_new_byte", 32'(cu_byte), 32'h5A);
    check("t3_new_pc", 32'(cu_pc), 32'h1234);

    // Test 4: address wrap at FFFF
    flush = 1'b1;
    flush_addr = 16'hFFFF;
    step();
    flush = 1'b0;
    check("t4_state", 32'(dbg_state), 32'(S_DISCARD));
    ack(16'h00BB);
    step();
    check("t4_maddr0", 32'(mem_addr), 32'hFFFF);
    ack(16'h0011);
    check("t4_maddr1", 32'(mem_addr), 32'h0000);
    ack(16'h0022);
    check("t4_byte0", 32'(cu_byte), 32'h11);
    check("t4_pc0", 32'(cu_pc), 32'hFFFF);
    pop1();
    check("t4_byte1", 32'(cu_byte), 32'h22);
    check("t4_pc1", 32'(cu_pc), 32'h0000);

    // Flush with coincident ack and pop: data dropped, straight to IDLE
    flush = 1'b1;
    flush_addr = 16'h2000;
    mem_ack = 1'b1;
    mem_data_in = 16'h0077;
    cu_pop = 1'b1;
    step();
    flush = 1'b0;
    mem_ack = 1'b0;
    cu_pop = 1'b0;
    check("fa_state", 32'(dbg_state), 32'(S_IDLE));
    check("fa_rden", 32'(mem_read_en), 0);
    check("fa_valid", 32'(cu_byte_valid), 0);
    check("fa_pc", 32'(cu_pc), 32'h2000);
    step();
    check("fa_maddr", 32'(mem_addr), 32'h2000);
    ack(16'h0099);
    check("fa_byte", 32'(cu_byte), 32'h99);
    check("fa_pc2", 32'(cu_pc), 32'h2000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
